// File: rtl/pipe_enq_arbiter.sv
// rtl/pipe_enq_arbiter.sv - round-robin enq arbiter feeding a tagged 2-entry output FIFO
module pipe_enq_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 96,
  parameter int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        req_enq__ENA,
  input  logic [NREQ*WIDTH-1:0]  req_enq_v,
  output logic [NREQ-1:0]        req_enq__RDY,
  output logic                   out_enq__ENA,
  output logic [IDXW+WIDTH-1:0]  out_enq_v,
  input  logic                   out_enq__RDY
);

  localparam int OW = IDXW + WIDTH;

  logic [IDXW-1:0]  gnt_q, gnt_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [OW-1:0]    s0_q, s0_d, s1_q, s1_d;
  logic             not_full, acc, pop;
  logic [WIDTH-1:0] sel_v;
  logic [OW-1:0]    word;

  // Ready depends only on gnt_q/cnt_q, so ENA can never feed back into RDY.
  always_comb begin
    not_full     = (cnt_q != 2'd2);
    req_enq__RDY = '0;
    sel_v        = '0;
    acc          = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q == IDXW'(i)) begin
        req_enq__RDY[i] = not_full;
        sel_v           = req_enq_v[i*WIDTH +: WIDTH];
        acc             = req_enq__ENA[i] && not_full;
      end
    end
    pop  = (cnt_q != 2'd0) && out_enq__RDY;
    word = {gnt_q, sel_v};
  end

  assign out_enq__ENA = pop;
  assign out_enq_v    = s0_q;

  always_comb begin
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    s0_d  = s0_q;
    s1_d  = s1_q;
    // The pointer moves every non-full cycle, used or not, bounding each wait to NREQ cycles.
    if (not_full) begin
      gnt_d = (gnt_q == IDXW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
    end
    case ({acc, pop})
      2'b10: begin
        if (cnt_q == 2'd0) s0_d = word;
        else               s1_d = word;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        s0_d  = s1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          s0_d = word;
        end else begin
          s0_d = s1_q;
          s1_d = word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      gnt_q <= '0;
      cnt_q <= 2'd0;
      s0_q  <= '0;
      s1_q  <= '0;
    end else begin
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
    end
  end

endmodule
